// File: rtl/multi_mode_counter_param.sv
// Purpose : WIDTH-bit four-mode up/down game counter with registered extreme-value
//           events, per-side scores and an IDLE/RUN/OVER gameover/restart sequence.
// Latency : count, flags, scores and gameover all update one clock after the inputs
//           that cause them. Backpressure: none; en=0 holds the count while in RUN.
//
// Optional feature macro: MULTI_MODE_COUNTER_SATURATE_EN
//   undefined (default) : counting wraps modulo 2^WIDTH
//   defined             : up steps clamp at all ones, down steps clamp at zero
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   init      in   in IDLE: load init_val and start a game (ignored elsewhere)
//   init_val  in   [WIDTH-1:0] starting count, also remembered for restarts
//   en        in   count enable while in RUN
//   ctrl      in   [1:0] 00:+1  01:+STEP  10:-1  11:-STEP
//   count     out  [WIDTH-1:0] current count
//   winner    out  one-cycle pulse when a step lands on all ones
//   loser     out  one-cycle pulse when a step lands on zero
//   gameover  out  one-cycle pulse when a score reaches SCORE_MAX
//   who       out  [1:0] 01 loser side won, 10 winner side won; valid with gameover
//   win_cnt   out  [SCORE_W-1:0] winner score
//   lose_cnt  out  [SCORE_W-1:0] loser score

module multi_mode_counter_param #(
    parameter int WIDTH     = 4,
    parameter int STEP      = 2,
    parameter int SCORE_MAX = 15,
    parameter int SCORE_W   = $clog2(SCORE_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [WIDTH-1:0]   init_val,
    input  logic               en,
    input  logic [1:0]         ctrl,
    output logic [WIDTH-1:0]   count,
    output logic               winner,
    output logic               loser,
    output logic               gameover,
    output logic [1:0]         who,
    output logic [SCORE_W-1:0] win_cnt,
    output logic [SCORE_W-1:0] lose_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0]   ALL_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ZERO        = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   STEP_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0]   STEP_BIG    = WIDTH'(STEP);
    localparam logic [SCORE_W-1:0] SCORE_LIMIT = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] SCORE_ZERO  = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

    localparam logic [1:0] WHO_NONE  = 2'b00;
    localparam logic [1:0] WHO_LOSER = 2'b01;
    localparam logic [1:0] WHO_WIN   = 2'b10;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   held_init;
    logic [WIDTH-1:0]   held_init_nxt;
    logic [WIDTH-1:0]   count_nxt;
    logic               winner_nxt;
    logic               loser_nxt;
    logic               gameover_nxt;
    logic [1:0]         who_nxt;
    logic [SCORE_W-1:0] win_cnt_nxt;
    logic [SCORE_W-1:0] lose_cnt_nxt;

    // ------------------------------------------------------------------
    // Step arithmetic
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   step_mag;
    logic [WIDTH-1:0]   step_up;
    logic [WIDTH-1:0]   step_dn;
    logic [WIDTH-1:0]   step_res;
    logic [SCORE_W-1:0] win_inc;
    logic [SCORE_W-1:0] lose_inc;

    // ctrl[0] picks the magnitude, ctrl[1] picks the direction.
    assign step_mag = ctrl[0] ? STEP_BIG : STEP_ONE;

`ifdef MULTI_MODE_COUNTER_SATURATE_EN
    // One extra bit catches the carry out of the up step so it can clamp.
    logic [WIDTH:0] sum_ext;

    assign sum_ext = {1'b0, count} + {1'b0, step_mag};
    assign step_up = sum_ext[WIDTH] ? ALL_ONES : sum_ext[WIDTH-1:0];
    assign step_dn = (count < step_mag) ? ZERO : (count - step_mag);
`else
    // Plain WIDTH-bit arithmetic gives modulo-2^WIDTH wrap-around.
    assign step_up = count + step_mag;
    assign step_dn = count - step_mag;
`endif

    assign step_res = ctrl[1] ? step_dn : step_up;

    // Scores stay below SCORE_MAX while a game is running, so these cannot overflow.
    assign win_inc  = win_cnt  + SCORE_ONE;
    assign lose_inc = lose_cnt + SCORE_ONE;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        held_init_nxt = held_init;
        count_nxt     = count;
        winner_nxt    = 1'b0;
        loser_nxt     = 1'b0;
        gameover_nxt  = 1'b0;
        who_nxt       = WHO_NONE;
        win_cnt_nxt   = win_cnt;
        lose_cnt_nxt  = lose_cnt;

        case (state)
            ST_IDLE: begin
                // The load itself never raises winner/loser, whatever init_val is.
                if (init) begin
                    count_nxt     = init_val;
                    held_init_nxt = init_val;
                    win_cnt_nxt   = SCORE_ZERO;
                    lose_cnt_nxt  = SCORE_ZERO;
                    state_nxt     = ST_RUN;
                end
            end

            ST_RUN: begin
                if (en) begin
                    count_nxt = step_res;
                    // WIDTH >= 2 keeps all-ones and zero distinct, so at most
                    // one side scores per step.
                    if (step_res == ALL_ONES) begin
                        winner_nxt  = 1'b1;
                        win_cnt_nxt = win_inc;
                        if (win_inc == SCORE_LIMIT) begin
                            gameover_nxt = 1'b1;
                            who_nxt      = WHO_WIN;
                            state_nxt    = ST_OVER;
                        end
                    end else if (step_res == ZERO) begin
                        loser_nxt    = 1'b1;
                        lose_cnt_nxt = lose_inc;
                        if (lose_inc == SCORE_LIMIT) begin
                            gameover_nxt = 1'b1;
                            who_nxt      = WHO_LOSER;
                            state_nxt    = ST_OVER;
                        end
                    end
                end
            end

            ST_OVER: begin
                // Single-cycle state: restart from the remembered start value,
                // ignoring en and init.
                count_nxt    = held_init;
                win_cnt_nxt  = SCORE_ZERO;
                lose_cnt_nxt = SCORE_ZERO;
                state_nxt    = ST_RUN;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            held_init <= ZERO;
            count     <= ZERO;
            winner    <= 1'b0;
            loser     <= 1'b0;
            gameover  <= 1'b0;
            who       <= WHO_NONE;
            win_cnt   <= SCORE_ZERO;
            lose_cnt  <= SCORE_ZERO;
        end else begin
            state     <= state_nxt;
            held_init <= held_init_nxt;
            count     <= count_nxt;
            winner    <= winner_nxt;
            loser     <= loser_nxt;
            gameover  <= gameover_nxt;
            who       <= who_nxt;
            win_cnt   <= win_cnt_nxt;
            lose_cnt  <= lose_cnt_nxt;
        end
    end

endmodule
